// File: rtl/control_sequencer.sv
// Multi-cycle control unit: fetch (T0-T2), opcode-dependent execute (T3-T6), HALT on request.
// Outputs decode combinationally from the state register and ir; stop is sampled only when leaving a final step.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        stop,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        LOin,
    output logic        HIin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [3:0]  alu_op,
    output logic        run
);

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_NOP, C_ALU2, C_MULDIV, C_UNARY, C_HALT
    } op_class_t;

    state_t     state_q;
    state_t     state_d;
    state_t     after_final;
    op_class_t  op_class;
    logic [3:0] op_alu;
    logic [4:0] opcode;

    assign opcode = ir[31:27];

    // Where a completed instruction goes next; stop matters nowhere else.
    assign after_final = stop ? S_HALT : S_T0;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        op_class = C_NOP;
        op_alu   = 4'b0000;
        case (opcode)
            5'b00011: begin op_class = C_ALU2;   op_alu = 4'b0001; end
            5'b00100: begin op_class = C_ALU2;   op_alu = 4'b0010; end
            5'b00101: begin op_class = C_ALU2;   op_alu = 4'b0011; end
            5'b00110: begin op_class = C_ALU2;   op_alu = 4'b0100; end
            5'b00111: begin op_class = C_ALU2;   op_alu = 4'b0101; end
            5'b01000: begin op_class = C_ALU2;   op_alu = 4'b0110; end
            5'b01001: begin op_class = C_ALU2;   op_alu = 4'b0111; end
            5'b01010: begin op_class = C_ALU2;   op_alu = 4'b1000; end
            5'b01111: begin op_class = C_MULDIV; op_alu = 4'b1001; end
            5'b10000: begin op_class = C_MULDIV; op_alu = 4'b1010; end
            5'b10001: begin op_class = C_UNARY;  op_alu = 4'b1011; end
            5'b10010: begin op_class = C_UNARY;  op_alu = 4'b1100; end
            5'b11011: begin op_class = C_HALT;   op_alu = 4'b0000; end
            default:  begin op_class = C_NOP;    op_alu = 4'b0000; end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        PCout    = 1'b0;
        PCin     = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        LOin     = 1'b0;
        HIin     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        alu_op   = 4'b0000;
        run      = 1'b1;

        case (state_q)
            S_RST: begin
                state_d = S_T0;
            end
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zin     = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                state_d = S_T2;
            end
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                case (op_class)
                    C_ALU2, C_MULDIV: begin
                        Grb     = 1'b1;
                        Rout    = 1'b1;
                        Yin     = 1'b1;
                        state_d = S_T4;
                    end
                    C_UNARY: begin
                        Grb     = 1'b1;
                        Rout    = 1'b1;
                        Zin     = 1'b1;
                        alu_op  = op_alu;
                        state_d = S_T4;
                    end
                    C_HALT:  state_d = S_HALT;
                    default: state_d = after_final;
                endcase
            end
            S_T4: begin
                case (op_class)
                    C_ALU2, C_MULDIV: begin
                        Grc     = 1'b1;
                        Rout    = 1'b1;
                        Zin     = 1'b1;
                        alu_op  = op_alu;
                        state_d = S_T5;
                    end
                    C_UNARY: begin
                        Zlowout = 1'b1;
                        Gra     = 1'b1;
                        Rin     = 1'b1;
                        state_d = after_final;
                    end
                    // ir changed under an instruction; restart fetch rather than wander.
                    default: state_d = S_T0;
                endcase
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (op_class == C_MULDIV) begin
                    LOin    = 1'b1;
                    state_d = S_T6;
                end else begin
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                    state_d = after_final;
                end
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                state_d  = after_final;
            end
            S_HALT: begin
                run     = 1'b0;
                state_d = S_HALT;
            end
            default: state_d = S_RST;
        endcase
    end

    bus_single_driver: assert property (@(posedge clock) disable iff (clear)
        $onehot0({PCout, Zlowout, Zhighout, MDRout, Rout}));

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port `clock`, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port `clear`, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port `ir`, input, 32 bits: instruction register contents from the datapath; opcode = ir[31:27].
REQ-004 SHALL have port `stop`, input, 1 bit: halt request.
REQ-005 SHALL have outputs `PCout`, `PCin`, `IncPC`, `MARin`, `Zin`, `Zlowout`, `Zhighout`, `Read`, `MDRin`, `MDRout`, `IRin`, `Yin`, `LOin`, `HIin`, each 1 bit: datapath load/drive strobes.
REQ-006 SHALL have outputs `Gra`, `Grb`, `Grc`, `Rin`, `Rout`, each 1 bit: register-field select (ra = ir[26:23], rb = ir[22:19], rc = ir[18:15]) and general-register load/drive.
REQ-007 SHALL have output `alu_op`, 4 bits: ALU operation code.
REQ-008 SHALL have output `run`, 1 bit: 1 while executing, 0 when halted.

Function
REQ-009 SHALL implement states RST, T0, T1, T2, T3, T4, T5, T6, HALT in a state register.
REQ-010 SHALL decode all outputs combinationally from the state register and `ir` only; every strobe not listed for a state SHALL be 0, and `alu_op` SHALL be 0000.
REQ-011 SHALL use the opcode / `alu_op` map: add 00011/0001, sub 00100/0010, shr 00101/0011, shl 00110/0100, ror 00111/0101, rol 01000/0110, and 01001/0111, or 01010/1000, mul 01111/1001, div 10000/1010, neg 10001/1011, not 10010/1100, nop 11010/-, halt 11011/-.
REQ-012 SHALL treat any opcode not in REQ-011 as nop.
REQ-013 In RST, SHALL drive all strobes to 0 and `run` to 1; the next state SHALL be T0.
REQ-014 In T0, SHALL assert PCout, MARin, IncPC, Zin; the next state SHALL be T1.
REQ-015 In T1, SHALL assert Zlowout, PCin, Read, MDRin; the next state SHALL be T2.
REQ-016 In T2, SHALL assert MDRout, IRin; the next state SHALL be T3; `ir` is valid from T3 onward.
REQ-017 In T3, for two-operand ops (add..or, mul, div), SHALL assert Grb, Rout, Yin; the next state SHALL be T4.
REQ-018 In T3, for neg/not, SHALL assert Grb, Rout, Zin, with `alu_op` per opcode; the next state SHALL be T4.
REQ-019 In T3, for nop, SHALL assert no strobes; the next state SHALL be T0 (or HALT per REQ-025).
REQ-020 In T3, for halt, SHALL assert no strobes; the next state SHALL be HALT.
REQ-021 In T4, for two-operand ops, SHALL assert Grc, Rout, Zin, with `alu_op` per opcode; the next state SHALL be T5.
REQ-022 In T4, for neg/not, SHALL assert Zlowout, Gra, Rin; this is the final step.
REQ-023 In T5, for non-mul/div ops, SHALL assert Zlowout, Gra, Rin; this is the final step. For mul/div, SHALL assert Zlowout, LOin; the next state SHALL be T6.
REQ-024 In T6 (mul/div only), SHALL assert Zhighout, HIin; this is the final step.
REQ-025 On the rising edge that leaves a final step (including T3 nop), SHALL go to HALT if `stop`=1, else to T0; `stop` SHALL be ignored in all other states.
REQ-026 In HALT, SHALL drive `run`=0 and all strobes 0, and SHALL remain in HALT until `clear`.
REQ-027 Instruction latency SHALL be: nop 4 cycles, neg/not 5, ALU two-operand 6, mul/div 7 (T0 through the final step inclusive).
REQ-028 SHALL never assert Rout and Zlowout in the same state, and SHALL never assert two bus drivers (PCout, Zlowout, Zhighout, MDRout, Rout) in the same state.

Reset
REQ-029 `clear`=1 SHALL force state RST immediately, independent of `clock`, from any state including mid-instruction and HALT.
REQ-030 While `clear`=1, all strobes SHALL be 0 and `run` SHALL be 1.
REQ-031 After `clear` deasserts, the first rising edge SHALL enter T0.

Verification
REQ-032 Pulse `clear`, hold `ir`=0x18000000 (ir[31:27]=00011, add; ra=0, rb=0, rc=0) -> states RST,T0..T5,T0; T4 `alu_op`=0001 with Grc=Rout=Zin=1; T5 Zlowout=Gra=Rin=1.
REQ-033 `ir`=0x78000000 (ir[31:27]=01111, mul) -> T5 Zlowout=LOin=1, T6 Zhighout=HIin=1, back to T0 after 7 cycles.
REQ-034 `ir`=0x88000000 (ir[31:27]=10001, neg) -> T3 `alu_op`=1011 with Zin=1, T4 Rin=1, then T0.
REQ-035 `ir`=0xD8000000 (ir[31:27]=11011, halt) -> HALT after T3, `run`=0; stays in HALT for 10 cycles; `clear` returns to RST, `run`=1.
REQ-036 Assert `clear` asynchronously during T4 of an `or` -> state RST and all strobes 0 before the next clock edge.
REQ-037 Hold `stop`=1 from T1 of an `and` -> instruction completes T5, next state HALT; `stop`=1 during T0 of a fresh cycle has no effect until that instruction's final step.
